// File: rtl/l1i_tlb_pkg.sv
// Shared types and geometry for the L1 instruction TLB.
package l1i_tlb_pkg;

  localparam int PAGE_INDEX_BITS  = 20;
  localparam int NUM_L1I_TLB_WAYS = 4;
  localparam int NUM_L1I_TLB_SETS = 16;
  localparam int ASID_WIDTH       = 8;

  localparam int L1I_TLB_WAYS_WIDTH = $clog2(NUM_L1I_TLB_WAYS);
  localparam int L1I_TLB_SETS_WIDTH = $clog2(NUM_L1I_TLB_SETS);
  localparam int L1I_TLB_TAG_WIDTH  = PAGE_INDEX_BITS - L1I_TLB_SETS_WIDTH;

  typedef logic [PAGE_INDEX_BITS-1:0]    page_index_t;
  typedef logic [ASID_WIDTH-1:0]         asid_t;
  typedef logic [L1I_TLB_WAYS_WIDTH-1:0] l1i_tlb_way_idx_t;
  typedef logic [L1I_TLB_SETS_WIDTH-1:0] l1i_tlb_set_idx_t;

  // Entry layout at the default geometry; 'global' is a reserved word, hence is_global.
  typedef struct packed {
    logic                         valid;
    logic [L1I_TLB_TAG_WIDTH-1:0] tag;
    asid_t                        asid;
    logic                         is_global;
    page_index_t                  ppage;
    logic                         exe;
    logic                         supervisor;
  } l1i_tlb_entry_t;

  // Index width that stays at least one bit wide for single-entry dimensions.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/l1i_tlb_if.sv
// Lookup, fill and invalidate bus between the fetch/page-walk side and the TLB.
interface l1i_tlb_if
  import l1i_tlb_pkg::*;
#(
  parameter int ASID_W = ASID_WIDTH
);
  logic              lookup_en;
  page_index_t       lookup_vpage_idx;
  logic [ASID_W-1:0] lookup_asid;
  logic              lookup_valid;
  logic              lookup_hit;
  page_index_t       lookup_ppage_idx;
  logic              lookup_exe;
  logic              lookup_supervisor;

  logic              update_en;
  page_index_t       update_vpage_idx;
  logic [ASID_W-1:0] update_asid;
  page_index_t       update_ppage_idx;
  logic              update_global;
  logic              update_exe;
  logic              update_supervisor;

  logic              inval_page_en;
  logic              inval_asid_en;
  logic              inval_all_en;

  modport master (
    output lookup_en, lookup_vpage_idx, lookup_asid,
    input  lookup_valid, lookup_hit, lookup_ppage_idx, lookup_exe, lookup_supervisor,
    output update_en, update_vpage_idx, update_asid, update_ppage_idx,
    output update_global, update_exe, update_supervisor,
    output inval_page_en, inval_asid_en, inval_all_en
  );

  modport slave (
    input  lookup_en, lookup_vpage_idx, lookup_asid,
    output lookup_valid, lookup_hit, lookup_ppage_idx, lookup_exe, lookup_supervisor,
    input  update_en, update_vpage_idx, update_asid, update_ppage_idx,
    input  update_global, update_exe, update_supervisor,
    input  inval_page_en, inval_asid_en, inval_all_en
  );
endinterface

// File: rtl/l1i_tlb_way.sv
// One way of the TLB: per-set entries, lookup/command compares and flash clear.
module l1i_tlb_way
  import l1i_tlb_pkg::*;
#(
  parameter int NUM_SETS  = NUM_L1I_TLB_SETS,
  parameter int ASID_W    = ASID_WIDTH,
  parameter int SET_IDX_W = idx_width(NUM_SETS),
  parameter int TAG_W     = PAGE_INDEX_BITS - $clog2(NUM_SETS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SET_IDX_W-1:0] lookup_set,
  input  logic [TAG_W-1:0]     lookup_tag,
  input  logic [ASID_W-1:0]    lookup_asid,
  output logic                 lookup_hit,
  output page_index_t          lookup_ppage,
  output logic                 lookup_exe,
  output logic                 lookup_supervisor,
  input  logic [SET_IDX_W-1:0] cmd_set,
  input  logic [TAG_W-1:0]     cmd_tag,
  input  logic [ASID_W-1:0]    cmd_asid,
  input  logic                 cmd_global,
  input  page_index_t          cmd_ppage,
  input  logic                 cmd_exe,
  input  logic                 cmd_supervisor,
  input  logic                 page_inval,
  input  logic                 asid_inval,
  input  logic                 all_inval,
  input  logic                 fill_en,
  output logic                 fill_match,
  output logic                 set_valid
);

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ASID_W-1:0] asid;
    logic              is_global;
    page_index_t       ppage;
    logic              exe;
    logic              supervisor;
  } entry_t;

  entry_t mem_q [NUM_SETS];
  entry_t look_entry;
  entry_t cmd_entry;
  logic   page_match;

  assign look_entry = mem_q[lookup_set];
  assign cmd_entry  = mem_q[cmd_set];

  // Lookup compare; data is zeroed on a miss so the top can OR all ways together.
  always_comb begin
    lookup_hit        = look_entry.valid && (look_entry.tag == lookup_tag) &&
                        (look_entry.is_global || (look_entry.asid == lookup_asid));
    lookup_ppage      = '0;
    lookup_exe        = 1'b0;
    lookup_supervisor = 1'b0;
    if (lookup_hit) begin
      lookup_ppage      = look_entry.ppage;
      lookup_exe        = look_entry.exe;
      lookup_supervisor = look_entry.supervisor;
    end
  end

  // Command-side compares: page invalidate uses the lookup rule, fill also matches a global refill.
  always_comb begin
    set_valid  = cmd_entry.valid;
    page_match = cmd_entry.valid && (cmd_entry.tag == cmd_tag) &&
                 (cmd_entry.is_global || (cmd_entry.asid == cmd_asid));
    fill_match = cmd_entry.valid && (cmd_entry.tag == cmd_tag) &&
                 (cmd_entry.is_global || cmd_global || (cmd_entry.asid == cmd_asid));
  end

  // Entry storage with single-cycle flash clears; only valid bits need reset.
  always_ff @(posedge clk) begin
    if (reset || all_inval) begin
      for (int s = 0; s < NUM_SETS; s++) mem_q[s].valid <= 1'b0;
    end else if (asid_inval) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        if (!mem_q[s].is_global && (mem_q[s].asid == cmd_asid)) mem_q[s].valid <= 1'b0;
      end
    end else if (page_inval) begin
      if (page_match) mem_q[cmd_set].valid <= 1'b0;
    end else if (fill_en) begin
      mem_q[cmd_set].valid      <= 1'b1;
      mem_q[cmd_set].tag        <= cmd_tag;
      mem_q[cmd_set].asid       <= cmd_asid;
      mem_q[cmd_set].is_global  <= cmd_global;
      mem_q[cmd_set].ppage      <= cmd_ppage;
      mem_q[cmd_set].exe        <= cmd_exe;
      mem_q[cmd_set].supervisor <= cmd_supervisor;
    end
  end

endmodule

// File: rtl/l1i_tlb.sv
// Set-associative instruction TLB with ASIDs, global pages and flash invalidation.
module l1i_tlb
  import l1i_tlb_pkg::*;
#(
  parameter int NUM_WAYS = NUM_L1I_TLB_WAYS,
  parameter int NUM_SETS = NUM_L1I_TLB_SETS,
  parameter int ASID_W   = ASID_WIDTH
) (
  input logic       clk,
  input logic       reset,
  l1i_tlb_if.slave  bus
);

  localparam int SET_W     = $clog2(NUM_SETS);
  localparam int SET_IDX_W = idx_width(NUM_SETS);
  localparam int WAY_IDX_W = idx_width(NUM_WAYS);
  localparam int TAG_W     = PAGE_INDEX_BITS - SET_W;

  logic [SET_IDX_W-1:0] lookup_set;
  logic [TAG_W-1:0]     lookup_tag;
  logic [SET_IDX_W-1:0] cmd_set;
  logic [TAG_W-1:0]     cmd_tag;
  logic [ASID_W-1:0]    cmd_asid;

  // Masking and shifting instead of slicing keeps NUM_SETS = 1 legal.
  assign lookup_set = SET_IDX_W'(bus.lookup_vpage_idx & page_index_t'(NUM_SETS - 1));
  assign lookup_tag = TAG_W'(bus.lookup_vpage_idx >> SET_W);
  assign cmd_set    = SET_IDX_W'(bus.update_vpage_idx & page_index_t'(NUM_SETS - 1));
  assign cmd_tag    = TAG_W'(bus.update_vpage_idx >> SET_W);
  assign cmd_asid   = bus.update_asid;

  logic do_all, do_asid, do_page, do_fill;

  assign do_all  = bus.inval_all_en;
  assign do_asid = bus.inval_asid_en && !do_all;
  assign do_page = bus.inval_page_en && !bus.inval_asid_en && !do_all;
  assign do_fill = bus.update_en && !bus.inval_page_en && !bus.inval_asid_en && !do_all;

  logic                 way_hit   [NUM_WAYS];
  page_index_t          way_ppage [NUM_WAYS];
  logic                 way_exe   [NUM_WAYS];
  logic                 way_sup   [NUM_WAYS];
  logic                 way_match [NUM_WAYS];
  logic                 way_valid [NUM_WAYS];
  logic                 way_fill  [NUM_WAYS];
  logic [WAY_IDX_W-1:0] rr_q      [NUM_SETS];
  logic [WAY_IDX_W-1:0] victim;
  logic                 use_ptr;

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    assign way_fill[w] = do_fill && (victim == WAY_IDX_W'(w));

    l1i_tlb_way #(
      .NUM_SETS  (NUM_SETS),
      .ASID_W    (ASID_W),
      .SET_IDX_W (SET_IDX_W),
      .TAG_W     (TAG_W)
    ) u_way (
      .clk               (clk),
      .reset             (reset),
      .lookup_set        (lookup_set),
      .lookup_tag        (lookup_tag),
      .lookup_asid       (bus.lookup_asid),
      .lookup_hit        (way_hit[w]),
      .lookup_ppage      (way_ppage[w]),
      .lookup_exe        (way_exe[w]),
      .lookup_supervisor (way_sup[w]),
      .cmd_set           (cmd_set),
      .cmd_tag           (cmd_tag),
      .cmd_asid          (cmd_asid),
      .cmd_global        (bus.update_global),
      .cmd_ppage         (bus.update_ppage_idx),
      .cmd_exe           (bus.update_exe),
      .cmd_supervisor    (bus.update_supervisor),
      .page_inval        (do_page),
      .asid_inval        (do_asid),
      .all_inval         (do_all),
      .fill_en           (way_fill[w]),
      .fill_match        (way_match[w]),
      .set_valid         (way_valid[w])
    );
  end

  // Victim choice: existing match, else lowest invalid way, else the set's pointer.
  always_comb begin
    victim  = rr_q[cmd_set];
    use_ptr = 1'b1;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!way_valid[w]) begin
        victim  = WAY_IDX_W'(w);
        use_ptr = 1'b0;
      end
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (way_match[w]) begin
        victim  = WAY_IDX_W'(w);
        use_ptr = 1'b0;
      end
    end
  end

  // Round-robin pointers move only when a pointer-chosen victim was filled.
  always_ff @(posedge clk) begin
    if (reset || do_all) begin
      for (int s = 0; s < NUM_SETS; s++) rr_q[s] <= '0;
    end else if (do_fill && use_ptr) begin
      rr_q[cmd_set] <= (rr_q[cmd_set] == WAY_IDX_W'(NUM_WAYS - 1)) ? '0 : rr_q[cmd_set] + 1'b1;
    end
  end

  logic        any_hit;
  page_index_t any_ppage;
  logic        any_exe;
  logic        any_sup;

  // At most one way hits, so an OR across the zero-on-miss way outputs selects it.
  always_comb begin
    any_hit   = 1'b0;
    any_ppage = '0;
    any_exe   = 1'b0;
    any_sup   = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      any_hit   = any_hit | way_hit[w];
      any_ppage = any_ppage | way_ppage[w];
      any_exe   = any_exe | way_exe[w];
      any_sup   = any_sup | way_sup[w];
    end
  end

  logic        valid_q, hit_q, exe_q, sup_q;
  page_index_t ppage_q;

  // Registered lookup result, one cycle after the request.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      hit_q   <= 1'b0;
      ppage_q <= '0;
      exe_q   <= 1'b0;
      sup_q   <= 1'b0;
    end else begin
      valid_q <= bus.lookup_en;
      if (bus.lookup_en) begin
        hit_q   <= any_hit;
        ppage_q <= any_ppage;
        exe_q   <= any_exe;
        sup_q   <= any_sup;
      end
    end
  end

  assign bus.lookup_valid      = valid_q;
  assign bus.lookup_hit        = hit_q;
  assign bus.lookup_ppage_idx  = ppage_q;
  assign bus.lookup_exe        = exe_q;
  assign bus.lookup_supervisor = sup_q;

endmodule
